lp805x_syncg_rdr: RTL and testbench
===================================

// Module: lp805x_syncg_rdr
// PURPOSE
//  Read-end consumer for the lp805x_syncg two-entry clock-domain crossing, in the rclk domain.
//  Pulls words through the rget/rrdy handshake, captures data_out and buffers it in a DEPTH-entry FIFO.
//  Presents the buffered words to core-side logic as a valid/ready stream.
//  Optional flush discards the buffered words and any word in flight.
// PARAMETERS
//  DATA_WIDTH  40  word width; equals DATA_WIDTH of the lp805x_syncg instance.
//  DEPTH       4   local FIFO entries; power of two, at least 2.
//  AW          2   log2(DEPTH); count is AW+1 bits wide.
// PORTS
//  clk        in   1           rclk-domain clock.
//  rst        in   1           synchronous, active-high reset.
//  rrdy       in   1           crossing has a word to read (lp805x_syncg rrdy).
//  rget       out  1           read request (to lp805x_syncg rget).
//  data_in    in   DATA_WIDTH  lp805x_syncg data_out.
//  flush      in   1           drop all buffered and in-flight data.
//  out_valid  out  1           head word is valid.
//  out_ready  in   1           consumer accepts the head word.
//  out_data   out  DATA_WIDTH  head word.
//  level      out  AW+1        number of buffered words, 0..DEPTH.
// BEHAVIOUR
//  Clocking and reset
//  - Single clock. Reset is synchronous and active-high on clk.
//  - Reset values: rget=0, out_valid=0, level=0, FSM=S_IDLE. out_data is don't-care while out_valid=0.
//  Transfers
//  - Crossing transfer: rget&rrdy is high at a rising edge (call it edge N).
//  - data_in is valid after edge N and is captured at edge N+1.
//  - out_valid is high no earlier than after edge N+1.
//  FSM: S_IDLE and S_CAPT
//  - S_IDLE: rget = rrdy & ~flush & (level < DEPTH). Go to S_CAPT if a transfer happens, else stay.
//  - S_CAPT: rget=0. Push data_in unless flush is high. Always return to S_IDLE.
//  - rget is combinational from rrdy, state and level; it must not glitch high in S_CAPT.
//  Pop and simultaneous events
//  - Pop when out_valid & out_ready.
//  - Pop and capture in the same cycle: both happen and level is unchanged.
//  - level == DEPTH blocks new requests only. A capture already in flight always has room,
//    because level < DEPTH was required when rget was issued.
//  - Pointers wrap modulo DEPTH. level never exceeds DEPTH and never goes below 0.
//  - out_ready while out_valid=0 has no effect.
//  Flush and reset mid-operation
//  - Flush: next cycle level=0 and out_valid=0.
//  - Flush in S_CAPT: the captured word is discarded. The crossing pointer still advances, so that word is lost by design.
//  - Reset in S_CAPT: the word is dropped the same way. A crossing reset is applied with this reset.
// STRUCTURE
//  - Shared include lp805x_syncg_defs.vh: FSM state encodings S_IDLE=1'b0 and S_CAPT=1'b1.
//    The same include holds the default DATA_WIDTH (40).
//  - One sub-module: lp805x_sfifo (DATA_WIDTH, DEPTH, AW).
//    It is a synchronous FIFO with push, pop, flush, count, full and empty, and first-word data read combinationally.
//  - Top level: FSM, rget logic, glue.
// TESTING
//  - Reset: hold rst 3 cycles with rrdy=1 -> rget=0, out_valid=0, level=0 throughout.
//  - Single word: rrdy=1, data_in=40'hA5_0000_0001 after the accepting edge, out_ready=0
//    -> rget high 1 cycle; out_valid=1 after 2 edges, out_data=40'hA5_0000_0001, level=1.
//  - Fill: push 4 words 1..4 with out_ready=0 -> level=4, rget stays 0 while rrdy=1.
//    Drain with out_ready=1 -> words 1,2,3,4 in order, then out_valid=0.
//  - Simultaneous capture and pop at level=2 -> level stays 2, order is preserved, pointers wrap past entry 3.
//  - Flush in S_CAPT with level=3 -> level=0 next cycle, captured word never appears,
//    the next transfer delivers the following word.
//  - Full boundary: level=4 with a pop and rrdy=1 in the same cycle -> rget=0 in that cycle,
//    rget=1 in the next cycle (level=3).

Source files
------------

// File: rtl/lp805x_syncg_rdr_pkg.sv
// Shared definitions for the lp805x_syncg read-end consumer: FSM state encodings
// and the default crossing word width.
package lp805x_syncg_rdr_pkg;

    localparam int DEF_DATA_WIDTH = 40;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CAPT = 1'b1
    } rdr_state_e;

endpackage

// File: rtl/lp805x_sfifo.sv
// Small synchronous FIFO with flush, occupancy count and a combinational
// first-word-fall-through read port.
module lp805x_sfifo
    import lp805x_syncg_rdr_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = 4,
    parameter int AW         = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [AW:0]           count,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage has no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lp805x_syncg_rdr.sv
// Read-end consumer of the lp805x_syncg crossing: requests words with rget/rrdy,
// captures data_in one edge later and presents buffered words as a stream.
module lp805x_syncg_rdr
    import lp805x_syncg_rdr_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = 4,
    parameter int AW         = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rrdy,
    output logic                  rget,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [AW:0]           level,
    output rdr_state_e            state
);

    // Stream handshake: a word moves when out_valid & out_ready are both high at
    // a rising edge; out_valid stays up and out_data stays stable until then.

    logic push;
    logic pop;
    logic full;
    logic empty;

    // A request is only issued with room left, so the capture that follows never overflows.
    assign rget      = ~rst & (state == S_IDLE) & rrdy & ~flush & ~full;
    assign push      = (state == S_CAPT) & ~flush;
    assign pop       = out_valid & out_ready;
    assign out_valid = ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state <= rget ? S_CAPT : S_IDLE;
                S_CAPT:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    lp805x_sfifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (data_in),
        .rdata (out_data),
        .count (level),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_lp805x_syncg_rdr.sv
// Directed bench for lp805x_syncg_rdr: the bench plays the crossing side and
// the core-side consumer, with hand-computed expectations.
module tb_lp805x_syncg_rdr;
    import lp805x_syncg_rdr_pkg::*;

    localparam int DW = 40;

    logic          clk;
    logic          rst;
    logic          rrdy;
    logic          rget;
    logic [DW-1:0] data_in;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [2:0]    level;
    rdr_state_e    state;

    int errors;
    int checks;

    lp805x_syncg_rdr #(
        .DATA_WIDTH (DW),
        .DEPTH      (4),
        .AW         (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rrdy      (rrdy),
        .rget      (rget),
        .data_in   (data_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .state     (state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow after a further settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // One crossing transfer: request cycle, then capture cycle with the word on data_in.
    task automatic xfer(input logic [DW-1:0] word, input logic pop_on_capt);
        rrdy      = 1'b1;
        out_ready = 1'b0;
        settle();
        check("xfer_rget_req", rget, 1);
        tick();
        data_in   = word;
        rrdy      = 1'b0;
        out_ready = pop_on_capt;
        settle();
        check("xfer_rget_capt", rget, 0);
        check("xfer_state_capt", state, S_CAPT);
        tick();
        out_ready = 1'b0;
    endtask

    task automatic drain_expect(input logic [DW-1:0] word);
        out_ready = 1'b1;
        settle();
        check("drain_valid", out_valid, 1);
        check("drain_data", out_data, word);
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        rrdy      = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;

        // reset held 3 cycles with rrdy high
        for (int i = 0; i < 3; i++) begin
            tick();
            settle();
            check("rst_rget", rget, 0);
            check("rst_valid", out_valid, 0);
            check("rst_level", level, 0);
            check("rst_state", state, S_IDLE);
        end
        rrdy = 1'b0;
        rst  = 1'b0;
        tick();

        // single word
        rrdy = 1'b1;
        settle();
        check("single_rget", rget, 1);
        tick();
        data_in = 40'hA5_0000_0001;
        rrdy    = 1'b0;
        settle();
        check("single_rget_low", rget, 0);
        check("single_valid_early", out_valid, 0);
        tick();
        settle();
        check("single_valid", out_valid, 1);
        check("single_data", out_data, 40'hA5_0000_0001);
        check("single_level", level, 1);
        drain_expect(40'hA5_0000_0001);
        settle();
        check("single_empty", out_valid, 0);

        // out_ready while empty does nothing
        out_ready = 1'b1;
        tick();
        settle();
        check("idle_pop_level", level, 0);
        out_ready = 1'b0;

        // fill to 4, requests blocked while full
        for (int i = 1; i <= 4; i++) xfer(DW'(i), 1'b0);
        check("fill_level", level, 4);
        rrdy = 1'b1;
        settle();
        check("fill_rget_blocked", rget, 0);
        tick();
        settle();
        check("fill_rget_blocked2", rget, 0);
        check("fill_state", state, S_IDLE);
        rrdy = 1'b0;
        for (int i = 1; i <= 4; i++) drain_expect(DW'(i));
        settle();
        check("fill_drained_valid", out_valid, 0);
        check("fill_drained_level", level, 0);

        // capture and pop together at level 2; write pointer wraps past entry 3
        xfer(40'h11, 1'b0);
        xfer(40'h12, 1'b0);
        xfer(40'h13, 1'b0);
        drain_expect(40'h11);
        check("sim_level_pre", level, 2);
        xfer(40'h14, 1'b1);
        settle();
        check("sim_level_a", level, 2);
        check("sim_head_a", out_data, 40'h13);
        xfer(40'h15, 1'b1);
        settle();
        check("sim_level_b", level, 2);
        drain_expect(40'h14);
        drain_expect(40'h15);
        check("sim_empty", out_valid, 0);

        // flush while a capture is in flight at level 3
        xfer(40'h21, 1'b0);
        xfer(40'h22, 1'b0);
        xfer(40'h23, 1'b0);
        check("flush_level_pre", level, 3);
        rrdy = 1'b1;
        settle();
        check("flush_rget_req", rget, 1);
        tick();
        data_in = 40'h24;
        rrdy    = 1'b0;
        flush   = 1'b1;
        settle();
        check("flush_rget_low", rget, 0);
        tick();
        flush = 1'b0;
        settle();
        check("flush_level", level, 0);
        check("flush_valid", out_valid, 0);
        check("flush_state", state, S_IDLE);
        xfer(40'h25, 1'b0);
        settle();
        check("flush_next_level", level, 1);
        drain_expect(40'h25);
        check("flush_next_empty", out_valid, 0);

        // full boundary: pop at level 4 with rrdy high
        for (int i = 0; i < 4; i++) xfer(DW'(40'h31 + i), 1'b0);
        rrdy      = 1'b1;
        out_ready = 1'b1;
        settle();
        check("full_rget_pop_cycle", rget, 0);
        check("full_head", out_data, 40'h31);
        tick();
        out_ready = 1'b0;
        settle();
        check("full_level_after_pop", level, 3);
        check("full_rget_next", rget, 1);
        tick();
        data_in = 40'h35;
        rrdy    = 1'b0;
        tick();
        settle();
        check("full_level_refill", level, 4);
        for (int i = 0; i < 4; i++) drain_expect(DW'(40'h32 + i));
        check("full_drained", level, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
